sprite_blitter: RTL and testbench
=================================

// Module: sprite_blitter
// PURPOSE
//  Copies one rotated sprite (SPR_SIZE x SPR_SIZE, 4-bit pixels) from the sprite ROM into the framebuffer.
//  - Reading side: drives the ROM's column, row, angle and enable inputs; takes the registered pixel one cycle later.
//  - Writing side: writes each non-transparent, on-screen pixel at (pos_x+col, pos_y+row) over a ready/valid port.
//  - Started once per object per frame by the game controller.
// PARAMETERS
//  SPR_SIZE      36     sprite edge in pixels
//  ANGLE_AMOUNT  16     rotation frames stored in the ROM
//  FB_W          320    framebuffer width in pixels
//  FB_H          240    framebuffer height in pixels
//  FB_AW         17     framebuffer address width, >= clog2(FB_W*FB_H)
//  TRANSP        4'h0   pixel value treated as transparent (never written)
// PORTS
//  CLK        in   1      clock; all flops update on posedge
//  RST_N      in   1      asynchronous reset, active low
//  start      in   1      request a blit; sampled only in IDLE
//  pos_x      in   9      top-left x of the sprite; latched on accepted start
//  pos_y      in   9      top-left y of the sprite; latched on accepted start
//  angle      in   4      rotation frame; latched on accepted start
//  busy       out  1      high in READ, WAIT and WRITE
//  done       out  1      one-cycle pulse when the blit completes
//  rom_en     out  1      ROM enable: pixel-inside-sprite flag
//  rom_hc     out  9      ROM column, 0..SPR_SIZE-1
//  rom_vc     out  9      ROM row, 0..SPR_SIZE-1
//  rom_angle  out  4      ROM rotation frame
//  rom_pixel  in   4      ROM data, registered, valid 1 cycle after the request
//  fb_we      out  1      framebuffer write valid
//  fb_addr    out  FB_AW  framebuffer address = y*FB_W + x
//  fb_data    out  4      framebuffer write pixel
//  fb_ready   in   1      framebuffer accepts the write when (fb_we && fb_ready)
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; counters 0. Reset is asynchronous and may assert mid-blit:
//   the blit is abandoned immediately and no done pulse is produced.
//  States: IDLE, READ, WAIT, WRITE, DONE.
//  IDLE: on start=1, latch pos_x, pos_y, angle; clear row and col; go to READ. Otherwise stay.
//  READ: rom_en=1, rom_hc=col, rom_vc=row, rom_angle=latched angle; always go to WAIT.
//   rom_* are 0 outside READ.
//  WAIT: rom_pixel is valid in this state. Compute x=pos_x+col and y=pos_y+row at 10-bit width (no wrap).
//   The pixel is skipped if rom_pixel==TRANSP, x>=FB_W or y>=FB_H.
//   Skipped pixel: advance, then go to READ, or to DONE after the last pixel.
//   Pixel not skipped: register fb_addr, fb_data and fb_we=1, then go to WRITE.
//  WRITE: hold fb_we, fb_addr and fb_data stable until fb_ready=1.
//   On handshake, drop fb_we in the next cycle, advance, then go to READ or DONE.
//   A fb_ready stall has no time limit.
//  Advance: col++ ; when col==SPR_SIZE-1, col=0 and row++. The last pixel is row=col=SPR_SIZE-1.
//  DONE: done=1 for exactly one cycle, busy=0, then IDLE.
//  start in any state other than IDLE is ignored and is not queued.
//  Timing with fb_ready tied high: 3 cycles per written pixel, 2 per skipped pixel, plus 1 DONE cycle.
//  fb_addr arithmetic: y*FB_W + x computed at full width, then truncated to FB_AW. Only in-range pixels reach this step.
// CONFIGURATION
//  BLIT_MIRROR_EN defined:
//   - adds input mirror_x (1 bit), latched on accepted start;
//   - when the latched value is 1, rom_hc = SPR_SIZE-1-col; destination x is still pos_x+col.
//  BLIT_MIRROR_EN undefined: no mirror_x port; rom_hc = col.
// STRUCTURE
//  Shared package sprite_pkg holds SPR_SIZE, ANGLE_AMOUNT, FB_W, FB_H, TRANSP and the state encoding localparams.
//  One sub-module, blit_addr_gen: owns the row/col counters, the advance/last logic and the x/y/clip computation.
//  The FSM and the framebuffer port stay in the top module.
//  The bench uses a behavioural ROM model with 1-cycle registered read.
// TESTING
//  - All-opaque sprite (pixel=5), pos=(0,0), angle=0, fb_ready=1:
//    1296 writes, addr 0..35 for row 0; done 3889 cycles after start.
//  - All-TRANSP sprite: zero fb_we pulses; done exactly 2593 cycles after start.
//  - pos=(300,230): only 20x10=200 writes; max addr = 239*320+319 = 76799.
//  - fb_ready low for 5 cycles during the first write:
//    fb_we, addr and data are held unchanged; the pixel is written exactly once.
//  - start pulsed while busy, then RST_N low in the middle of a blit:
//    the extra start has no effect; after reset busy=0, done=0, fb_we=0, and the next start blits normally.
//  - BLIT_MIRROR_EN with mirror_x=1, col 0:
//    rom_hc=35 and the pixel is written at x=pos_x.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared sizes, state encoding and the latched blit request for the sprite blitter.
// BLIT_MIRROR_EN adds a horizontal-mirror flag to the request.
package sprite_pkg;

    localparam int unsigned SPR_SIZE     = 36;
    localparam int unsigned ANGLE_AMOUNT = 16;
    localparam int unsigned FB_W         = 320;
    localparam int unsigned FB_H         = 240;
    localparam int unsigned FB_AW_DEF    = 17;

    localparam int unsigned PIX_W       = 4;
    localparam int unsigned POS_W       = 9;
    localparam int unsigned COORD_W     = 10;
    localparam int unsigned ROM_CW      = 9;
    localparam int unsigned ADDR_FULL_W = 20;
    localparam int unsigned CNT_W       = $clog2(SPR_SIZE);
    localparam int unsigned ANGLE_W     = $clog2(ANGLE_AMOUNT);

    localparam logic [PIX_W-1:0] TRANSP = 4'h0;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    typedef struct packed {
        logic [POS_W-1:0]   pos_x;
        logic [POS_W-1:0]   pos_y;
        logic [ANGLE_W-1:0] angle;
`ifdef BLIT_MIRROR_EN
        logic               mirror;
`endif
    } blit_req_t;

    // Linear framebuffer address at full width; callers truncate.
    function automatic logic [ADDR_FULL_W-1:0] fb_lin_addr(input logic [COORD_W-1:0] x,
                                                           input logic [COORD_W-1:0] y);
        return ADDR_FULL_W'(y) * ADDR_FULL_W'(FB_W) + ADDR_FULL_W'(x);
    endfunction

endpackage

// File: rtl/sprite_blitter_addr_gen.sv
// blit_addr_gen: sprite row/column walk, last-pixel detect and on-screen clipping.
module blit_addr_gen
    import sprite_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               clear_i,
    input  logic               advance_i,
    input  logic [POS_W-1:0]   pos_x_i,
    input  logic [POS_W-1:0]   pos_y_i,
    output logic [CNT_W-1:0]   col_nxt_c,
    output logic [CNT_W-1:0]   row_nxt_c,
    output logic               last_c,
    output logic               clip_c,
    output logic [COORD_W-1:0] x_c,
    output logic [COORD_W-1:0] y_c
);

    logic [CNT_W-1:0] col_q, col_d;
    logic [CNT_W-1:0] row_q, row_d;
    logic             col_wrap;

    assign col_wrap = (col_q == CNT_W'(SPR_SIZE - 1));
    assign last_c   = col_wrap && (row_q == CNT_W'(SPR_SIZE - 1));

    // Raster-order advance; row increments when the column wraps.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clear_i) begin
            col_d = '0;
            row_d = '0;
        end else if (advance_i) begin
            if (col_wrap) begin
                col_d = '0;
                row_d = row_q + CNT_W'(1);
            end else begin
                col_d = col_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign col_nxt_c = col_d;
    assign row_nxt_c = row_d;

    // 10-bit sums cannot wrap for 9-bit positions plus a 6-bit offset.
    assign x_c    = COORD_W'(pos_x_i) + COORD_W'(col_q);
    assign y_c    = COORD_W'(pos_y_i) + COORD_W'(row_q);
    assign clip_c = (x_c >= COORD_W'(FB_W)) || (y_c >= COORD_W'(FB_H));

endmodule

// File: rtl/sprite_blitter.sv
// Copies one rotated sprite from the sprite ROM into the framebuffer, skipping
// transparent and off-screen pixels. Define BLIT_MIRROR_EN for the mirror_x input.
module sprite_blitter
    import sprite_pkg::*;
#(
    parameter int unsigned FB_AW = FB_AW_DEF
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               start,
    input  logic [POS_W-1:0]   pos_x,
    input  logic [POS_W-1:0]   pos_y,
    input  logic [ANGLE_W-1:0] angle,
`ifdef BLIT_MIRROR_EN
    input  logic               mirror_x,
`endif
    output logic               busy,
    output logic               done,
    output logic               rom_en,
    output logic [ROM_CW-1:0]  rom_hc,
    output logic [ROM_CW-1:0]  rom_vc,
    output logic [ANGLE_W-1:0] rom_angle,
    input  logic [PIX_W-1:0]   rom_pixel,
    output logic               fb_we,
    output logic [FB_AW-1:0]   fb_addr,
    output logic [PIX_W-1:0]   fb_data,
    input  logic               fb_ready
);

    logic [2:0]         state_q, state_d;
    blit_req_t          req_q, req_d;
    logic               clear, advance, load_fb, skip;

    logic [CNT_W-1:0]   col_nxt, row_nxt;
    logic               last, clip;
    logic [COORD_W-1:0] x, y;
    logic [ROM_CW-1:0]  hc_sel;

    logic               busy_q, done_q, rom_en_q, fb_we_q;
    logic [ROM_CW-1:0]  rom_hc_q, rom_vc_q;
    logic [ANGLE_W-1:0] rom_angle_q;
    logic [FB_AW-1:0]   fb_addr_q;
    logic [PIX_W-1:0]   fb_data_q;

    blit_addr_gen u_addr_gen (
        .clk_i     (CLK),
        .rst_ni    (RST_N),
        .clear_i   (clear),
        .advance_i (advance),
        .pos_x_i   (req_q.pos_x),
        .pos_y_i   (req_q.pos_y),
        .col_nxt_c (col_nxt),
        .row_nxt_c (row_nxt),
        .last_c    (last),
        .clip_c    (clip),
        .x_c       (x),
        .y_c       (y)
    );

    assign skip = (rom_pixel == TRANSP) || clip;

    // Column presented to the ROM for the pixel about to be read.
    always_comb begin
        hc_sel = ROM_CW'(col_nxt);
`ifdef BLIT_MIRROR_EN
        if (req_d.mirror) begin
            hc_sel = ROM_CW'(SPR_SIZE - 1) - ROM_CW'(col_nxt);
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        clear   = 1'b0;
        advance = 1'b0;
        load_fb = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    req_d.pos_x = pos_x;
                    req_d.pos_y = pos_y;
                    req_d.angle = angle;
`ifdef BLIT_MIRROR_EN
                    req_d.mirror = mirror_x;
`endif
                    clear   = 1'b1;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (skip) begin
                    advance = 1'b1;
                    state_d = last ? S_DONE : S_READ;
                end else begin
                    load_fb = 1'b1;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (fb_ready) begin
                    advance = 1'b1;
                    state_d = last ? S_DONE : S_READ;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they belong to.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= S_IDLE;
            req_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rom_en_q    <= 1'b0;
            rom_hc_q    <= '0;
            rom_vc_q    <= '0;
            rom_angle_q <= '0;
            fb_we_q     <= 1'b0;
            fb_addr_q   <= '0;
            fb_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            busy_q      <= (state_d == S_READ) || (state_d == S_WAIT) || (state_d == S_WRITE);
            done_q      <= (state_d == S_DONE);
            rom_en_q    <= (state_d == S_READ);
            rom_hc_q    <= (state_d == S_READ) ? hc_sel : '0;
            rom_vc_q    <= (state_d == S_READ) ? ROM_CW'(row_nxt) : '0;
            rom_angle_q <= (state_d == S_READ) ? req_d.angle : '0;
            fb_we_q     <= (state_d == S_WRITE);
            if (load_fb) begin
                fb_addr_q <= FB_AW'(fb_lin_addr(x, y));
                fb_data_q <= rom_pixel;
            end
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign rom_en    = rom_en_q;
    assign rom_hc    = rom_hc_q;
    assign rom_vc    = rom_vc_q;
    assign rom_angle = rom_angle_q;
    assign fb_we     = fb_we_q;
    assign fb_addr   = fb_addr_q;
    assign fb_data   = fb_data_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter with a behavioural 1-cycle registered sprite ROM.
module tb_sprite_blitter;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        start = 1'b0;
    logic [8:0]  pos_x = '0;
    logic [8:0]  pos_y = '0;
    logic [3:0]  angle = '0;
`ifdef BLIT_MIRROR_EN
    logic        mirror_x = 1'b0;
`endif
    logic        busy, done, rom_en, fb_we;
    logic [8:0]  rom_hc, rom_vc;
    logic [3:0]  rom_angle, fb_data;
    logic [3:0]  rom_pixel = 4'h0;
    logic [16:0] fb_addr;
    logic        fb_ready = 1'b1;

    sprite_blitter dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .start     (start),
        .pos_x     (pos_x),
        .pos_y     (pos_y),
        .angle     (angle),
`ifdef BLIT_MIRROR_EN
        .mirror_x  (mirror_x),
`endif
        .busy      (busy),
        .done      (done),
        .rom_en    (rom_en),
        .rom_hc    (rom_hc),
        .rom_vc    (rom_vc),
        .rom_angle (rom_angle),
        .rom_pixel (rom_pixel),
        .fb_we     (fb_we),
        .fb_addr   (fb_addr),
        .fb_data   (fb_data),
        .fb_ready  (fb_ready)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;
    int edge_n = 0;
    int t0 = 0;
    int cyc;
    int n;
    int stable_bad;

    // Stimulus-side expectations read by the monitor.
    int         rom_mode = 0;
    int         exp_base = 0;
    int         watch_addr = -1;
    logic [3:0] exp_angle = 4'h0;
    logic [3:0] exp_data = 4'h0;
    bit         mirror_exp = 1'b0;
    bit         row0_check = 1'b0;

    // Monitor statistics, cleared when a start is accepted.
    int     rd_idx = 0, rd_bad = 0, wr_cnt = 0, we_cyc = 0;
    int     row0_bad = 0, data_bad = 0, done_cnt = 0, watch_hits = 0;
    longint max_addr = -1, min_addr = 64'd1 << 40;

    function automatic logic [3:0] rom_fn(input int mode, input logic [8:0] hc, input logic [8:0] vc);
        case (mode)
            0:       return 4'h5;
            1:       return 4'h0;
            2:       return (hc == vc) ? 4'hA : 4'h0;
            default: return (hc == 9'd35) ? 4'h7 : 4'h0;
        endcase
    endfunction

    always @(posedge CLK) begin
        edge_n++;
        if (rom_en) rom_pixel <= rom_fn(rom_mode, rom_hc, rom_vc);
    end

    always @(negedge CLK) begin
        int ec, er;
        if (start && !busy) begin
            rd_idx = 0; rd_bad = 0; wr_cnt = 0; we_cyc = 0;
            row0_bad = 0; data_bad = 0; done_cnt = 0; watch_hits = 0;
            max_addr = -1; min_addr = 64'd1 << 40;
        end
        if (rom_en) begin
            ec = rd_idx % 36;
            er = rd_idx / 36;
            if (rom_hc !== 9'(mirror_exp ? 35 - ec : ec) || rom_vc !== 9'(er) || rom_angle !== exp_angle)
                rd_bad++;
            rd_idx++;
        end
        if (fb_we) we_cyc++;
        if (fb_we && fb_ready) begin
            if (row0_check && wr_cnt < 36 && fb_addr !== 17'(exp_base + wr_cnt)) row0_bad++;
            if (fb_data !== exp_data) data_bad++;
            if (longint'(fb_addr) > max_addr) max_addr = longint'(fb_addr);
            if (longint'(fb_addr) < min_addr) min_addr = longint'(fb_addr);
            if (int'(fb_addr) == watch_addr) watch_hits++;
            wr_cnt++;
        end
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_blit(input logic [8:0] px, input logic [8:0] py, input logic [3:0] ang);
        pos_x = px;
        pos_y = py;
        angle = ang;
        start = 1'b1;
        tick();
        start = 1'b0;
        t0 = edge_n;
    endtask

    // Latency counts posedges from the one that samples start up to the one raising done.
    task automatic wait_done(input int limit, output int cycles);
        int k;
        k = 0;
        while (done !== 1'b1 && k < limit) begin
            tick();
            k++;
        end
        cycles = (done === 1'b1) ? (edge_n - t0 + 1) : -1;
    endtask

    initial begin
        RST_N = 1'b0;
        tick();
        tick();
        check("rst_busy",   64'(busy),    64'd0);
        check("rst_done",   64'(done),    64'd0);
        check("rst_fb_we",  64'(fb_we),   64'd0);
        check("rst_rom_en", 64'(rom_en),  64'd0);
        check("rst_rom_hc", 64'(rom_hc),  64'd0);
        check("rst_fb_addr",64'(fb_addr), 64'd0);
        RST_N = 1'b1;
        tick();

        // Fully opaque sprite at the origin.
        rom_mode = 0; exp_data = 4'h5; exp_angle = 4'h0; exp_base = 0; row0_check = 1'b1;
        start_blit(9'd0, 9'd0, 4'd0);
        wait_done(5000, cyc);
        check("opaque_cycles",  64'(cyc),      64'd3889);
        check("opaque_busy",    64'(busy),     64'd0);
        check("opaque_writes",  64'(wr_cnt),   64'd1296);
        check("opaque_row0",    64'(row0_bad), 64'd0);
        check("opaque_data",    64'(data_bad), 64'd0);
        check("opaque_reads",   64'(rd_idx),   64'd1296);
        check("opaque_rd_seq",  64'(rd_bad),   64'd0);
        check("opaque_max",     64'(max_addr), 64'd11235);
        tick();
        check("opaque_done_len",64'(done),     64'd0);

        // Fully transparent sprite, non-zero angle.
        rom_mode = 1; exp_angle = 4'h7; row0_check = 1'b0;
        start_blit(9'd0, 9'd0, 4'd7);
        wait_done(5000, cyc);
        check("transp_cycles",  64'(cyc),      64'd2593);
        check("transp_we",      64'(we_cyc),   64'd0);
        check("transp_rd_seq",  64'(rd_bad),   64'd0);
        check("transp_reads",   64'(rd_idx),   64'd1296);
        tick();

        // Bottom-right corner clipping.
        rom_mode = 0; exp_data = 4'h5; exp_angle = 4'h2;
        start_blit(9'd300, 9'd230, 4'd2);
        wait_done(5000, cyc);
        check("clip_cycles",    64'(cyc),      64'd2793);
        check("clip_writes",    64'(wr_cnt),   64'd200);
        check("clip_max",       64'(max_addr), 64'd76799);
        check("clip_min",       64'(min_addr), 64'd73900);
        check("clip_data",      64'(data_bad), 64'd0);
        tick();

        // Diagonal sprite with the first write stalled for 5 cycles.
        rom_mode = 2; exp_data = 4'hA; exp_angle = 4'h0; watch_addr = 6410;
        fb_ready = 1'b0;
        start_blit(9'd10, 9'd20, 4'd0);
        n = 0;
        while (fb_we !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("stall_first_we", 64'(fb_we), 64'd1);
        stable_bad = 0;
        for (int k = 0; k < 5; k++) begin
            if (fb_we !== 1'b1 || fb_addr !== 17'd6410 || fb_data !== 4'hA) stable_bad++;
            tick();
        end
        check("stall_hold",     64'(stable_bad), 64'd0);
        check("stall_no_write", 64'(wr_cnt),     64'd0);
        fb_ready = 1'b1;
        wait_done(5000, cyc);
        check("stall_cycles",   64'(cyc),        64'd2634);
        check("stall_writes",   64'(wr_cnt),     64'd36);
        check("stall_once",     64'(watch_hits), 64'd1);
        check("stall_max",      64'(max_addr),   64'd17645);
        check("stall_data",     64'(data_bad),   64'd0);
        tick();

        // Start while busy is ignored; reset mid-blit abandons it.
        rom_mode = 0; exp_data = 4'h5; exp_angle = 4'h0; watch_addr = -1;
        start_blit(9'd0, 9'd0, 4'd0);
        repeat (50) tick();
        pos_x = 9'd200; pos_y = 9'd200; angle = 4'd9;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (50) tick();
        check("busy_start_busy",  64'(busy),               64'd1);
        check("busy_start_rdseq", 64'(rd_bad),             64'd0);
        check("busy_start_addr",  64'(max_addr <= 11235),  64'd1);
        check("busy_start_wrote", 64'(wr_cnt > 0),         64'd1);
        RST_N = 1'b0;
        #1;
        check("midrst_busy",   64'(busy),   64'd0);
        check("midrst_done",   64'(done),   64'd0);
        check("midrst_fb_we",  64'(fb_we),  64'd0);
        check("midrst_rom_en", 64'(rom_en), 64'd0);
        tick();
        tick();
        check("midrst_no_done", 64'(done_cnt), 64'd0);
        RST_N = 1'b1;
        tick();

        exp_base = 1605; row0_check = 1'b1;
        start_blit(9'd5, 9'd5, 4'd0);
        wait_done(5000, cyc);
        check("post_rst_cycles", 64'(cyc),      64'd3889);
        check("post_rst_writes", 64'(wr_cnt),   64'd1296);
        check("post_rst_row0",   64'(row0_bad), 64'd0);
        check("post_rst_min",    64'(min_addr), 64'd1605);
        tick();

`ifdef BLIT_MIRROR_EN
        // Mirrored read: only ROM column 35 is opaque, landing at x = pos_x.
        rom_mode = 3; exp_data = 4'h7; row0_check = 1'b0;
        mirror_x = 1'b1; mirror_exp = 1'b1;
        start_blit(9'd40, 9'd50, 4'd0);
        wait_done(5000, cyc);
        check("mirror_cycles", 64'(cyc),      64'd2629);
        check("mirror_writes", 64'(wr_cnt),   64'd36);
        check("mirror_min",    64'(min_addr), 64'd16040);
        check("mirror_max",    64'(max_addr), 64'd27240);
        check("mirror_rd_seq", 64'(rd_bad),   64'd0);
        check("mirror_data",   64'(data_bad), 64'd0);
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
